// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I decode constants
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_SUB    = 2'b01,
    ALU_RFUNCT = 2'b10,
    ALU_IFUNCT = 2'b11
  } alu_op_t;

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - 2R/1W register file with write-back bypass, x0 hardwired to zero
module register_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1Data,
  output logic [XLEN-1:0] rs2Data,
  input  logic            wbRegWrite,
  input  logic [AW-1:0]   wbRd,
  input  logic [XLEN-1:0] wbData
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wbActive;

  assign wbActive = wbRegWrite && (wbRd != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wbActive) begin
      regs[wbRd] <= wbData;
    end
  end

  // Same-cycle write-back forwards straight to the reader.
  always_comb begin
    rs1Data = '0;
    rs2Data = '0;
    if (rs1 != '0) rs1Data = (wbActive && wbRd == rs1) ? wbData : regs[rs1];
    if (rs2 != '0) rs2Data = (wbActive && wbRd == rs2) ? wbData : regs[rs2];
  end

endmodule

// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - RV32I decode stage: decoder, immediates, load-use hazard, ID/EX register
module instruction_decode #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     ifIdInstruction,
  input  logic [XLEN-1:0] ifIdIn,
  input  logic            flush,
  input  logic            wbRegWrite,
  input  logic [4:0]      wbRd,
  input  logic [XLEN-1:0] wbData,
  output logic            stall,
  output logic [XLEN-1:0] idExNpc,
  output logic [XLEN-1:0] idExRs1Data,
  output logic [XLEN-1:0] idExRs2Data,
  output logic [XLEN-1:0] idExImm,
  output logic [4:0]      idExRs1,
  output logic [4:0]      idExRs2,
  output logic [4:0]      idExRd,
  output logic [3:0]      idExFunct,
  output logic [1:0]      idExAluOp,
  output logic            idExAluSrc,
  output logic            idExMemRead,
  output logic            idExMemWrite,
  output logic            idExRegWrite,
  output logic            idExMemToReg,
  output logic            idExBranch,
  output logic            idExValid,
  output logic            idExIllegal
);
  import riscv_pkg::*;

  logic [31:0]     instr;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rs1Data, rs2Data, imm;
  logic            dRegWrite, dAluSrc, dMemRead, dMemWrite, dMemToReg, dBranch;
  logic            usesRs1, usesRs2, legal, dIllegal;
  alu_op_t         dAluOp;

  assign instr = ifIdInstruction;
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign rd    = instr[11:7];

  register_file #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clock      (clock),
    .reset      (reset),
    .rs1        (rs1),
    .rs2        (rs2),
    .rs1Data    (rs1Data),
    .rs2Data    (rs2Data),
    .wbRegWrite (wbRegWrite),
    .wbRd       (wbRd),
    .wbData     (wbData)
  );

  always_comb begin
    dRegWrite = 1'b0;
    dAluSrc   = 1'b0;
    dMemRead  = 1'b0;
    dMemWrite = 1'b0;
    dMemToReg = 1'b0;
    dBranch   = 1'b0;
    dAluOp    = ALU_ADD;
    imm       = '0;
    usesRs1   = 1'b0;
    usesRs2   = 1'b0;
    legal     = 1'b1;
    case (instr[6:0])
      OP_R: begin
        dRegWrite = 1'b1; dAluOp = ALU_RFUNCT;
        usesRs1 = 1'b1; usesRs2 = 1'b1;
      end
      OP_IMM: begin
        dRegWrite = 1'b1; dAluSrc = 1'b1; dAluOp = ALU_IFUNCT;
        imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
        usesRs1 = 1'b1;
      end
      OP_LOAD: begin
        dRegWrite = 1'b1; dAluSrc = 1'b1; dMemRead = 1'b1; dMemToReg = 1'b1;
        imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
        usesRs1 = 1'b1;
      end
      OP_STORE: begin
        dMemWrite = 1'b1; dAluSrc = 1'b1;
        imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
        usesRs1 = 1'b1; usesRs2 = 1'b1;
      end
      OP_BRANCH: begin
        dBranch = 1'b1; dAluOp = ALU_SUB;
        imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        usesRs1 = 1'b1; usesRs2 = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // The all-zero word is the IF/ID reset value, so it is a bubble rather than illegal.
  assign dIllegal = !legal && (instr != 32'h0);

  assign stall = !flush && idExValid && idExMemRead && (idExRd != 5'd0) &&
                 ((usesRs1 && idExRd == rs1) || (usesRs2 && idExRd == rs2));

  always_ff @(posedge clock) begin
    if (reset) begin
      idExNpc      <= '0;
      idExRs1Data  <= '0;
      idExRs2Data  <= '0;
      idExImm      <= '0;
      idExRs1      <= '0;
      idExRs2      <= '0;
      idExRd       <= '0;
      idExFunct    <= '0;
      idExAluOp    <= '0;
      idExAluSrc   <= 1'b0;
      idExMemRead  <= 1'b0;
      idExMemWrite <= 1'b0;
      idExRegWrite <= 1'b0;
      idExMemToReg <= 1'b0;
      idExBranch   <= 1'b0;
      idExValid    <= 1'b0;
      idExIllegal  <= 1'b0;
    end else begin
      idExNpc     <= ifIdIn;
      idExRs1Data <= rs1Data;
      idExRs2Data <= rs2Data;
      idExImm     <= imm;
      idExRs1     <= rs1;
      idExRs2     <= rs2;
      idExRd      <= rd;
      idExFunct   <= {instr[30], instr[14:12]};
      if (flush || stall) begin
        idExAluOp    <= '0;
        idExAluSrc   <= 1'b0;
        idExMemRead  <= 1'b0;
        idExMemWrite <= 1'b0;
        idExRegWrite <= 1'b0;
        idExMemToReg <= 1'b0;
        idExBranch   <= 1'b0;
        idExValid    <= 1'b0;
        idExIllegal  <= 1'b0;
      end else begin
        idExAluOp    <= dAluOp;
        idExAluSrc   <= dAluSrc;
        idExMemRead  <= dMemRead;
        idExMemWrite <= dMemWrite;
        idExRegWrite <= dRegWrite;
        idExMemToReg <= dMemToReg;
        idExBranch   <= dBranch;
        idExValid    <= legal;
        idExIllegal  <= dIllegal;
      end
    end
  end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Second pipeline stage of the 5-stage RV32I core; consumes `ifIdInstruction`/`ifIdIn` from the fetch stage's IF/ID register.
- Decodes the subset R-ALU, I-ALU, LW, SW, BEQ.
- Holds the 32x32 register file, with a write-back port and write-through bypass.
- Generates immediates, detects load-use hazards (stalls fetch) and owns the ID/EX pipeline register.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, architectural registers; x0 hardwired to zero.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ifIdInstruction  in  32  instruction from IF/ID.
- ifIdIn  in  32  PC+4 of that instruction.
- flush  in  1  branch taken in EX/MEM; squash the ID instruction.
- wbRegWrite  in  1  write-back enable.
- wbRd  in  5  write-back destination.
- wbData  in  32  write-back value.
- stall  out  1  combinational; fetch holds PC and IF/ID when 1.
- idExNpc  out  32  registered PC+4.
- idExRs1Data  out  32  registered operand A.
- idExRs2Data  out  32  registered operand B / store data.
- idExImm  out  32  registered sign-extended immediate.
- idExRs1, idExRs2, idExRd  out  5 each  registered register indices.
- idExFunct  out  4  {funct7[5], funct3}.
- idExAluOp  out  2  00 add, 01 sub, 10 R-funct, 11 I-funct.
- idExAluSrc, idExMemRead, idExMemWrite, idExRegWrite, idExMemToReg, idExBranch  out  1 each  registered controls.
- idExValid  out  1  slot holds a real instruction.
- idExIllegal  out  1  unsupported opcode was decoded.

Behaviour:
- Reset (synchronous): all ID/EX outputs 0; all 32 registers 0; stall 0 in the cycle after reset.
- Register file writes:
  - Write at posedge when wbRegWrite=1 and wbRd!=0.
  - Writes to x0 are ignored; reads of x0 return 0.
- Register file reads:
  - Reads are combinational.
  - Bypass: if wbRegWrite=1, wbRd!=0 and wbRd==rsN, the read returns wbData in the same cycle.
- Decode by opcode [6:0]:
  - 0110011 (R): RegWrite, AluOp 10; uses rs1 and rs2.
  - 0010011 (I-ALU): RegWrite, AluSrc, AluOp 11; imm I; uses rs1.
  - 0000011 (LW): RegWrite, AluSrc, MemRead, MemToReg, AluOp 00; imm I; uses rs1.
  - 0100011 (SW): MemWrite, AluSrc, AluOp 00; imm S; uses rs1 and rs2.
  - 1100011 (BEQ): Branch, AluOp 01; imm B; uses rs1 and rs2.
- Immediates:
  - I = sext([31:20]).
  - S = sext({[31:25],[11:7]}).
  - B = sext({[31],[7],[30:25],[11:8],1'b0}).
  - Other formats: imm = 0.
- Instruction 0x00000000 (IF/ID reset value) decodes as a bubble: Valid=0, Illegal=0.
- Any other unsupported opcode: controls 0, Valid=0, Illegal=1 for one cycle.
- Load-use hazard:
  - stall = !flush & idExValid & idExMemRead & idExRd!=0 & ((usesRs1 & idExRd==rs1) | (usesRs2 & idExRd==rs2)).
- ID/EX update, every posedge, in priority order:
  - reset: all outputs 0.
  - flush: bubble (all controls 0, Valid=0, Illegal=0).
  - stall: bubble.
  - otherwise: load the decoded instruction, Valid=1.
- Bubble data fields (Npc, data, Imm, indices) may be 0 or don't-care; the bench checks only controls and Valid.
- Latency: one cycle from IF/ID to ID/EX.
- A stall lasts exactly one cycle for a single load-use pair: the next cycle's ID/EX holds a bubble, so the hazard clears.
- flush and stall together: flush wins, stall=0.
- Simultaneous WB write and ID read of the same register: the new value is used (bypass).
- Reset mid-stall: stall drops the cycle after reset, since idExValid=0.

Decomposition:
- riscv_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH);
  - AluOp encodings;
  - the XLEN constant.
- Sub-module `register_file`: 2 combinational read ports with WB bypass, 1 synchronous write port, x0 forced zero.
- Decoder, immediate generator, hazard logic and ID/EX register stay in `instruction_decode`.

Test Plan:
- Reset, then `ifIdInstruction`=0x00000000 → all idEx outputs 0, stall=0, Valid=0, Illegal=0.
- WB x5=0x0000_00AA, then `addi x6,x5,-1` (0xFFF28313), ifIdIn=0x8 → next cycle Rs1Data=0xAA, Imm=0xFFFFFFFF, Rd=6, AluSrc=1, AluOp=11, RegWrite=1, Npc=0x8.
- Same cycle: wbRegWrite=1, wbRd=5, wbData=0x1234; `add x7,x5,x5` in ID → Rs1Data=Rs2Data=0x1234 (bypass).
- `lw x3,0(x1)` followed by `add x4,x3,x2` → stall=1 for exactly one cycle; ID/EX bubble (Valid=0, RegWrite=0); then add issues with Valid=1.
- `beq x1,x2,-8` (0xFE208CE3) with flush=1 in the same cycle → ID/EX bubble, stall=0; with flush=0 → Imm=0xFFFFFFF8, Branch=1, AluOp=01.
- Opcode 0x7F, then WB to x0 with 0xFFFF → Illegal=1, Valid=0; later reads of x0 return 0.
